// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised.
// Read data is presented combinationally from the head entry.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = UART_DATA_BITS
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        push,
   input  logic                        pop,
   input  logic [WIDTH-1:0]            din,
   output logic [WIDTH-1:0]            dout,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_check_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and >= 2");
   end

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next pointer and occupancy values.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge CLK or posedge RESET) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge CLK) begin
      // NOTE: storage is deliberately not reset; the cleared pointers make stale entries unreachable.
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a small FIFO,
// a baud-timed FSM serialises each byte LSB-first onto a registered TXD.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [UART_DATA_BITS-1:0]   wr_data,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   output logic                        TXD,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(UART_DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_check_cpb
      $error("uart_tx_buffered: CLKS_PER_BIT must be >= 2");
   end

   uart_state_t               state_q, state_d;
   logic [BAUD_W-1:0]         baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      txd_q, txd_d;
   logic                      busy_q, busy_d;

   logic                      fifo_pop, fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_dout;
   logic                      baud_wrap;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (UART_DATA_BITS)
   ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (wr_valid),
      .pop   (fifo_pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign wr_ready  = !fifo_full;
   assign baud_wrap = (baud_cnt_q == BAUD_LAST);
   assign busy_d    = (state_q != IDLE) || (fifo_count != '0);
   assign TXD       = txd_q;
   assign busy      = busy_q;

   // FSM state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic: bit boundaries occur on the baud counter wrap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = START;
         START:   if (baud_wrap) state_d = DATA;
         DATA:    if (baud_wrap && bit_idx_q == BIT_LAST) state_d = STOP;
         STOP:    if (baud_wrap) state_d = fifo_empty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: FIFO pop, line level and datapath next values.
   // TXD is registered from the current state, so the line lags the FSM by one cycle.
   always_comb begin
      fifo_pop   = 1'b0;
      txd_d      = UART_IDLE_LEVEL;
      baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BAUD_W'(1);
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            fifo_pop   = !fifo_empty;
         end
         START: begin
            txd_d = 1'b0;
            if (baud_wrap) bit_idx_d = '0;
         end
         DATA: begin
            txd_d = shift_q[0];
            if (baud_wrap) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + BIT_W'(1);
            end
         end
         STOP: begin
            // Popping on the last stop cycle chains frames with no idle gap.
            fifo_pop = baud_wrap && !fifo_empty;
         end
         default: ;
      endcase
      if (fifo_pop) shift_d = fifo_dout;
   end

   // Datapath and output registers; reset forces the line idle at once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         txd_q      <= UART_IDLE_LEVEL;
         busy_q     <= 1'b0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
      end
   end

endmodule
